// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_pkg
//  Purpose  : Shared types and constants for the pipeline trace tagger.
//             stage_tag_t travels through the shadow pipeline stages.
//             retire_rec_t is the record queued for the trace consumer.
//             The struct fields are sized for the widest supported
//             SEQ_W (16) and CYC_W (32). Narrower configurations
//             zero-extend into these fields.
//  Revision : 1.0  initial release
// ============================================================================
package trace_pkg;

  localparam int         TAG_SEQ_W = 16;
  localparam int         TAG_CYC_W = 32;
  localparam logic [7:0] STALL_SAT = 8'hFF;

  typedef struct packed {
    logic                 valid;
    logic [TAG_SEQ_W-1:0] seq;
    logic [15:0]          pc;
    logic [15:0]          instr;
    logic [TAG_CYC_W-1:0] fetch_cycle;
    logic [7:0]           stall_cnt;
  } stage_tag_t;

  typedef struct packed {
    logic [TAG_SEQ_W-1:0] seq;
    logic [15:0]          pc;
    logic [15:0]          instr;
    logic [TAG_CYC_W-1:0] fetch_cycle;
    logic [TAG_CYC_W-1:0] retire_cycle;
    logic [7:0]           stall_cnt;
  } retire_rec_t;

  // Event counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : trace_fifo
//  Purpose  : Synchronous FIFO for retire records, with a registered output.
//             o_data shows the head entry and stays stable until it is
//             popped. o_data is zero while the FIFO is empty.
//             A push into a full FIFO is accepted only when a pop happens
//             in the same cycle. The caller decides how to count a push
//             that is refused.
//  Ports    : clk, rst          clock, synchronous active-high reset
//             i_push, i_data    write request and record
//             i_pop             read request (ignored when empty)
//             o_data            head record
//             o_full, o_empty   occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = retire_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int            c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = DEPTH[c_AW:0];

  T                r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == c_FULL);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // When the FIFO is full, a push with a pop in the same cycle writes into
  // the head slot as that slot is being vacated.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_trace_tagger.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_trace_tagger
//  Purpose  : Follows the 5-stage CPU pipeline in parallel and produces a
//             trace. It uses the CPU's own fetch, stall and flush controls.
//             Each accepted fetch gets a sequence ID and a cycle stamp.
//             The tag then moves through the IF/ID, ID/EX, EX/MEM and
//             MEM/WB shadow stages. When the tag reaches MEM/WB, one
//             record is pushed into the retire FIFO.
//  Ports    : clk, rst                     clock, sync active-high reset
//             i_fetch_valid/pc/instr       fetch stage inputs
//             i_stall, i_flush             CPU pipeline controls
//             o_out_valid, i_out_ready     retire record stream handshake
//             o_out_*                      retire record fields
//             o_cycle_count                free-running cycle counter
//             o_retired/flushed/drop_count saturating event counters
//             o_overflow                   sticky flag, set on first drop
//  Revision : 1.0  initial release
//  SEQ_W must be <= 16 and CYC_W must be <= 32, to match the trace_pkg
//  field widths.
// ============================================================================
module pipe_trace_tagger
  import trace_pkg::*;
#(
  parameter int SEQ_W = 16,
  parameter int CYC_W = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fetch_valid,
  input  logic [15:0]      i_fetch_pc,
  input  logic [15:0]      i_fetch_instr,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [SEQ_W-1:0] o_out_seq,
  output logic [15:0]      o_out_pc,
  output logic [15:0]      o_out_instr,
  output logic [CYC_W-1:0] o_out_fetch_cycle,
  output logic [CYC_W-1:0] o_out_retire_cycle,
  output logic [7:0]       o_out_stall_cycles,
  output logic [CYC_W-1:0] o_cycle_count,
  output logic [31:0]      o_retired_count,
  output logic [31:0]      o_flushed_count,
  output logic [31:0]      o_drop_count,
  output logic             o_overflow
);

  stage_tag_t       r_if_id, r_id_ex, r_ex_mem, r_mem_wb;
  logic [SEQ_W-1:0] r_next_seq;
  logic [CYC_W-1:0] r_cycle;
  logic [31:0]      r_retired, r_flushed, r_drops;
  logic             r_overflow;

  logic             w_accept;
  logic             w_kill;
  stage_tag_t       w_new_tag;
  retire_rec_t      w_push_rec;
  retire_rec_t      w_head_rec;
  logic             w_fifo_full, w_fifo_empty;
  logic             w_pop, w_drop, w_stored;

  // Stall has priority over flush, so a flush seen during a stall is ignored.
  assign w_accept = i_fetch_valid && !i_stall && !i_flush;
  assign w_kill   = i_fetch_valid && !i_stall &&  i_flush;

  always_comb begin
    w_new_tag             = '0;
    w_new_tag.valid       = 1'b1;
    w_new_tag.seq         = TAG_SEQ_W'(r_next_seq);
    w_new_tag.pc          = i_fetch_pc;
    w_new_tag.instr       = i_fetch_instr;
    w_new_tag.fetch_cycle = TAG_CYC_W'(r_cycle);
  end

  always_comb begin
    w_push_rec              = '0;
    w_push_rec.seq          = r_mem_wb.seq;
    w_push_rec.pc           = r_mem_wb.pc;
    w_push_rec.instr        = r_mem_wb.instr;
    w_push_rec.fetch_cycle  = r_mem_wb.fetch_cycle;
    w_push_rec.retire_cycle = TAG_CYC_W'(r_cycle);
    w_push_rec.stall_cnt    = r_mem_wb.stall_cnt;
  end

  assign w_pop    = o_out_valid && i_out_ready;
  assign w_drop   = r_mem_wb.valid && w_fifo_full && !w_pop;
  assign w_stored = r_mem_wb.valid && !w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_id    <= '0;
      r_id_ex    <= '0;
      r_ex_mem   <= '0;
      r_mem_wb   <= '0;
      r_next_seq <= '0;
      r_cycle    <= '0;
      r_retired  <= '0;
      r_flushed  <= '0;
      r_drops    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_stall) begin
        // IF/ID holds its tag and counts how long it waits. A bubble
        // enters ID/EX.
        if (r_if_id.valid && (r_if_id.stall_cnt != STALL_SAT))
          r_if_id.stall_cnt <= r_if_id.stall_cnt + 8'd1;
        r_id_ex <= '0;
      end else begin
        r_id_ex <= r_if_id;
        r_if_id <= w_accept ? w_new_tag : '0;
      end
      r_ex_mem <= r_id_ex;
      r_mem_wb <= r_ex_mem;

      if (w_accept) r_next_seq <= r_next_seq + SEQ_W'(1);
      r_cycle <= r_cycle + CYC_W'(1);

      if (w_stored) r_retired <= sat_inc32(r_retired);
      if (w_kill)   r_flushed <= sat_inc32(r_flushed);
      if (w_drop) begin
        r_drops    <= sat_inc32(r_drops);
        r_overflow <= 1'b1;
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (retire_rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_mem_wb.valid),
    .i_data  (w_push_rec),
    .i_pop   (w_pop),
    .o_data  (w_head_rec),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_out_valid        = !w_fifo_empty;
  assign o_out_seq          = w_head_rec.seq[SEQ_W-1:0];
  assign o_out_pc           = w_head_rec.pc;
  assign o_out_instr        = w_head_rec.instr;
  assign o_out_fetch_cycle  = w_head_rec.fetch_cycle[CYC_W-1:0];
  assign o_out_retire_cycle = w_head_rec.retire_cycle[CYC_W-1:0];
  assign o_out_stall_cycles = w_head_rec.stall_cnt;
  assign o_cycle_count      = r_cycle;
  assign o_retired_count    = r_retired;
  assign o_flushed_count    = r_flushed;
  assign o_drop_count       = r_drops;
  assign o_overflow         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_tagger.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_trace_tagger
//  Purpose  : Self-checking bench for pipe_trace_tagger. Each task writes
//             the expected retire records into a scoreboard queue at the
//             point where it drives the matching fetch. The monitor takes
//             records off the queue as the DUT hands them out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_trace_tagger;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic [15:0] fetch_instr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_seq, out_pc, out_instr;
  logic [31:0] out_fetch_cycle, out_retire_cycle, cycle_count;
  logic [7:0]  out_stall_cycles;
  logic [31:0] retired_count, flushed_count, drop_count;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int tb_cyc = 0;

  typedef struct {
    logic [15:0] seq;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [31:0] fc;
    logic [31:0] rc;
    logic [7:0]  st;
    int          popc;   // expected pop cycle, -1 = not checked
  } exp_t;

  exp_t q[$];

  pipe_trace_tagger #(.SEQ_W(16), .CYC_W(32), .DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_fetch_valid      (fetch_valid),
    .i_fetch_pc         (fetch_pc),
    .i_fetch_instr      (fetch_instr),
    .i_stall            (stall),
    .i_flush            (flush),
    .o_out_valid        (out_valid),
    .i_out_ready        (out_ready),
    .o_out_seq          (out_seq),
    .o_out_pc           (out_pc),
    .o_out_instr        (out_instr),
    .o_out_fetch_cycle  (out_fetch_cycle),
    .o_out_retire_cycle (out_retire_cycle),
    .o_out_stall_cycles (out_stall_cycles),
    .o_cycle_count      (cycle_count),
    .o_retired_count    (retired_count),
    .o_flushed_count    (flushed_count),
    .o_drop_count       (drop_count),
    .o_overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Bench cycle number: 0 in the first cycle after reset is released.
  always_ff @(posedge clk) tb_cyc <= rst ? 0 : tb_cyc + 1;

  function automatic logic [15:0] instr_of(input logic [15:0] pc);
    return pc ^ 16'hBEEF;
  endfunction

  task automatic push_exp(input int seq, input int pc, input int fc,
                          input int rc, input int st, input int popc);
    exp_t e;
    e.seq = 16'(seq); e.pc = 16'(pc); e.instr = instr_of(16'(pc));
    e.fc = 32'(fc); e.rc = 32'(rc); e.st = 8'(st); e.popc = popc;
    q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got seq=%0d pc=%h, required no record", out_seq, out_pc);
      end else begin
        e = q.pop_front();
        if (out_seq !== e.seq) begin errors++; $display("FAIL rec_seq: got %0d required %0d", out_seq, e.seq); end
        checks++;
        if (out_pc !== e.pc) begin errors++; $display("FAIL rec_pc seq%0d: got %h required %h", e.seq, out_pc, e.pc); end
        checks++;
        if (out_instr !== e.instr) begin errors++; $display("FAIL rec_instr seq%0d: got %h required %h", e.seq, out_instr, e.instr); end
        checks++;
        if (out_fetch_cycle !== e.fc) begin errors++; $display("FAIL rec_fetch_cycle seq%0d: got %0d required %0d", e.seq, out_fetch_cycle, e.fc); end
        checks++;
        if (out_retire_cycle !== e.rc) begin errors++; $display("FAIL rec_retire_cycle seq%0d: got %0d required %0d", e.seq, out_retire_cycle, e.rc); end
        checks++;
        if (out_stall_cycles !== e.st) begin errors++; $display("FAIL rec_stall_cycles seq%0d: got %0d required %0d", e.seq, out_stall_cycles, e.st); end
        if (e.popc >= 0) begin
          checks++;
          if (tb_cyc != e.popc) begin errors++; $display("FAIL rec_valid_cycle seq%0d: got %0d required %0d", e.seq, tb_cyc, e.popc); end
        end
      end
    end
  endtask

  // Advance one cycle. Outputs are sampled on the falling edge, and new
  // inputs go in 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [15:0] pc, input logic st, input logic fl);
    fetch_valid = fv; fetch_pc = pc; fetch_instr = instr_of(pc); stall = st; flush = fl;
  endtask

  task automatic apply_reset();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    q.delete();
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (q.size() != 0 && n < max_cycles) begin step(); n++; end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d records outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (out_seq !== 16'd0) begin errors++; $display("FAIL reset_out_seq: got %0d required 0", out_seq); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle_count: got %0d required 0", cycle_count); end
    checks++; if ({retired_count, flushed_count, drop_count} !== 96'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d/%0d required 0/0/0", retired_count, flushed_count, drop_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    step(); step(); step();
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL cycle_count_run: got %0d required 3", cycle_count); end
  endtask

  task automatic test_basic();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(i, 2 * i, i, i + 4, 0, i + 5);
      drive(1'b1, 16'(2 * i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    wait_drain(20);
    step(); step();
    checks++; if (retired_count !== 32'd3) begin errors++; $display("FAIL basic_retired: got %0d required 3", retired_count); end
  endtask

  task automatic test_stall();
    apply_reset();
    out_ready = 1'b1;
    push_exp(0, 16'h0, 0, 4, 0, 5);
    push_exp(1, 16'h2, 1, 7, 2, 8);
    push_exp(2, 16'h4, 4, 8, 0, 9);
    drive(1'b1, 16'h0, 1'b0, 1'b0); step();
    drive(1'b1, 16'h2, 1'b0, 1'b0); step();
    drive(1'b1, 16'h4, 1'b1, 1'b0); step();
    drive(1'b1, 16'h4, 1'b1, 1'b0); step();
    drive(1'b1, 16'h4, 1'b0, 1'b0); step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    wait_drain(20);
    step();
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b1;
    push_exp(0, 16'h0, 0, 4, 0, 5);
    push_exp(1, 16'h4, 2, 6, 0, 7);
    drive(1'b1, 16'h0, 1'b0, 1'b0); step();
    drive(1'b1, 16'h2, 1'b0, 1'b1); step();
    drive(1'b1, 16'h4, 1'b0, 1'b0); step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    wait_drain(20);
    step(); step();
    checks++; if (flushed_count !== 32'd1) begin errors++; $display("FAIL flush_count: got %0d required 1", flushed_count); end
    checks++; if (retired_count !== 32'd2) begin errors++; $display("FAIL flush_retired: got %0d required 2", retired_count); end
  endtask

  task automatic test_stall_and_flush();
    apply_reset();
    out_ready = 1'b1;
    push_exp(0, 16'h0, 0, 5, 1, 6);
    push_exp(1, 16'h2, 2, 6, 0, 7);
    drive(1'b1, 16'h0, 1'b0, 1'b0); step();
    drive(1'b1, 16'h2, 1'b1, 1'b1); step();
    drive(1'b1, 16'h2, 1'b0, 1'b0); step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    wait_drain(20);
    step();
    checks++; if (flushed_count !== 32'd0) begin errors++; $display("FAIL stall_flush_count: got %0d required 0", flushed_count); end
  endtask

  task automatic test_overflow();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'(16'h40 + 2 * i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_seq !== 16'd0) begin errors++; $display("FAIL ovf_head_early: got valid=%b seq=%0d required valid=1 seq=0", out_valid, out_seq); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (out_valid !== 1'b1 || out_seq !== 16'd0 || out_pc !== 16'h40) begin errors++; $display("FAIL ovf_head_hold: got valid=%b seq=%0d pc=%h required valid=1 seq=0 pc=0040", out_valid, out_seq, out_pc); end
    checks++; if (drop_count !== 32'd2) begin errors++; $display("FAIL ovf_drop_count: got %0d required 2", drop_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    checks++; if (retired_count !== 32'd4) begin errors++; $display("FAIL ovf_retired: got %0d required 4", retired_count); end
    for (int i = 0; i < 4; i++) push_exp(i, 16'h40 + 2 * i, i, i + 4, 0, -1);
    out_ready = 1'b1;
    wait_drain(12);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty_after: got %b required 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(16'h80 + 2 * i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    step();
    checks++; if (retired_count !== 32'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_reset: got retired=%0d valid=%b required 2 and 1", retired_count, out_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b required 0", out_valid); end
    checks++; if ({retired_count, flushed_count, drop_count, cycle_count} !== 128'd0) begin errors++; $display("FAIL mid_reset_counters: got %0d/%0d/%0d/%0d required 0/0/0/0", retired_count, flushed_count, drop_count, cycle_count); end
    out_ready = 1'b1;
    push_exp(0, 16'h100, 0, 4, 0, 5);
    drive(1'b1, 16'h100, 1'b0, 1'b0); step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    wait_drain(12);
    for (int i = 0; i < 8; i++) step();
    checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL mid_reset_retired: got %0d required 1", retired_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_stall_and_flush();
    test_overflow();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pipe_trace_tagger.md
Name: pipe_trace_tagger

Overview:
- Synthesizable trace producer that shadows the 5-stage CPU pipeline (IF, ID, EX, MEM, WB) using the CPU's own fetch, stall and flush controls.
- Tags each accepted instruction with a sequence ID and cycle stamp, then carries the tag through shadow stage registers.
- At retirement, emits one record per instruction over a valid/ready stream through an internal FIFO.
- Feeds the bench-side pipeline checker and the trace dump.

Parameters:
- SEQ_W, 16, width of the sequence ID.
- CYC_W, 32, width of the cycle counter and stamps.
- DEPTH, 8, retire FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  the fetch stage presents a real instruction this cycle.
- fetch_pc  in  16  PC of the fetched instruction.
- fetch_instr  in  16  fetched instruction word.
- stall  in  1  CPU stall: PC and IF/ID hold, ID/EX receives a bubble.
- flush  in  1  CPU IF flush: the instruction being fetched is killed.
- out_valid  out  1  retire record available.
- out_ready  in  1  consumer accepts the record.
- out_seq  out  SEQ_W  sequence ID of the record.
- out_pc  out  16  PC of the retired instruction.
- out_instr  out  16  instruction word.
- out_fetch_cycle  out  CYC_W  cycle in which the instruction was accepted into IF/ID.
- out_retire_cycle  out  CYC_W  cycle in which the instruction occupied MEM/WB.
- out_stall_cycles  out  8  stall cycles accumulated in IF/ID, saturating at 255.
- cycle_count  out  CYC_W  free-running cycle counter.
- retired_count  out  32  records pushed into the FIFO.
- flushed_count  out  32  fetches killed by flush.
- drop_count  out  32  records lost to FIFO overflow.
- overflow  out  1  sticky flag, set on the first drop.

Behaviour:
- **Reset:**
  - All outputs are 0, all shadow stages are invalid, the FIFO is empty and the next sequence ID is 0.
  - Reset mid-operation discards in-flight tags and FIFO contents; nothing drains.
- **cycle_count:** 0 in the first cycle after rst falls, +1 every cycle, wraps modulo 2^CYC_W.
- **Stage tag contents:** valid, seq, pc, instr, fetch_cycle, stall_cnt.
- **Accept:** an instruction is accepted when fetch_valid && !stall && !flush.
  - IF/ID loads a tag with seq = next_seq, fetch_cycle = cycle_count, stall_cnt = 0.
  - next_seq then increments, wrapping modulo 2^SEQ_W.
- **Flush:** when flush && !stall, IF/ID loads a bubble.
  - flushed_count increments if fetch_valid is high.
  - next_seq is unchanged, so IDs stay contiguous over retired instructions.
- **Idle fetch:** !fetch_valid && !stall && !flush loads a bubble into IF/ID.
- **Stall:**
  - Stall has priority over flush; flush is ignored in a cycle where both are high.
  - IF/ID holds, and its stall_cnt increments (saturating at 255) if the tag is valid.
  - ID/EX loads a bubble.
- **Downstream shift:** otherwise ID/EX <- IF/ID. EX/MEM <- ID/EX and MEM/WB <- EX/MEM every cycle.
- **Retire:**
  - Whenever MEM/WB is valid, a record is pushed with retire_cycle = cycle_count in that cycle, and retired_count increments.
  - Unstalled latency: accepted in cycle N, in MEM/WB in cycle N+4, out_valid in N+5 when the FIFO was empty.
- **FIFO:**
  - Registered output; out_* hold stable while out_valid && !out_ready.
  - A pop occurs on out_valid && out_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - Push into a full FIFO without a pop drops the new record: drop_count increments, overflow sets, and retired_count does not increment.
  - Push into an empty FIFO makes out_valid high next cycle.
  - Pop of the last entry with no push makes out_valid low next cycle.
- **Saturation:** all 32-bit counters saturate at all-ones.

Decomposition:
- Package trace_pkg:
  - stage_tag_t struct (valid, seq, pc, instr, fetch_cycle, stall_cnt).
  - retire_rec_t struct (seq, pc, instr, fetch_cycle, retire_cycle, stall_cnt).
  - STALL_SAT = 8'hFF.
- Sub-module trace_fifo: parameterized on DEPTH and element type retire_rec_t; push/pop/full/empty interface.
- Top level holds the counters, the four shadow stages and the accept/stall/flush logic.

Test Plan:
- Reset, then fetch_valid=1 at PC 0x0000, 0x0002 and 0x0004 in cycles 0–2, no stall, out_ready=1 -> records seq 0,1,2 with fetch_cycle 0,1,2, retire_cycle 4,5,6 and stall_cycles 0; out_valid in cycles 5,6,7.
- stall high for cycles 2–3 while seq 1 sits in IF/ID -> seq 1 has stall_cycles=2 and retire_cycle 7; seq 2 is accepted at cycle 4 and retires at cycle 8.
- flush with fetch_valid=1 at cycle 1 -> flushed_count=1; the instruction accepted next gets seq 1 with no gap, and only 2 records appear for 3 fetch attempts.
- stall=1 and flush=1 in the same cycle -> flushed_count unchanged, IF/ID holds, stall_cnt increments.
- DEPTH=4, out_ready=0, 6 retirements -> out_valid=1 with seq 0 held stable, drop_count=2, overflow=1; raise out_ready -> records seq 0,1,2,3 in order, then out_valid=0.
- Assert rst for one cycle mid-stream with 3 tags in flight and 2 FIFO records -> next cycle out_valid=0 and all counters 0; the next accepted instruction gets seq 0 and fetch_cycle 0.
